// File: rtl/multi_bank_memory_if.sv
// Command/response bundle for multi_bank_memory: one command channel in,
// one read-beat channel out, both valid/ready.
interface multi_bank_memory_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int NUM_UNITS    = 2,
  parameter int NUM_BANKS    = 4
);
  localparam int DEPTH  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int K_W    = $clog2(IMAGE_WIDTH);

  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [1:0]                            cmd_op;
  logic [BANK_W-1:0]                     cmd_bank;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]      cmd_addr;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  cmd_data;
  logic [K_W-1:0]                        kernel_dim;
  logic                                  rd_valid;
  logic                                  rd_ready;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  rd_data;
  logic                                  rd_last;
  logic                                  busy;

  modport master (
    output cmd_valid, cmd_op, cmd_bank, cmd_addr, cmd_data, kernel_dim, rd_ready,
    input  cmd_ready, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bank, cmd_addr, cmd_data, kernel_dim, rd_ready,
    output cmd_ready, rd_valid, rd_data, rd_last, busy
  );
endinterface

// File: rtl/multi_bank_memory.sv
// NUM_BANKS image banks behind one command port: lane writes/reads, streamed
// zero-padded KxK window reads and whole-bank clear, with one output slot.
module multi_bank_memory #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int NUM_UNITS    = 2,
  parameter int NUM_BANKS    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_bank_memory_if.slave   bus
);
  localparam int DEPTH  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int K_W    = $clog2(IMAGE_WIDTH);

  localparam logic [1:0]        OP_WRITE  = 2'b00;
  localparam logic [1:0]        OP_READ   = 2'b01;
  localparam logic [1:0]        OP_WINDOW = 2'b10;
  localparam logic [1:0]        OP_CLEAR  = 2'b11;
  localparam logic [K_W-1:0]    K_ONE     = K_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0]                mem_r [NUM_BANKS][DEPTH];
  state_t                               state_r;
  logic                                 busy_r;
  logic                                 rd_valid_r;
  logic                                 rd_last_r;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] rd_data_r;
  logic [BANK_W-1:0]                    bank_r;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]     start_r;
  logic [K_W-1:0]                       k_r;
  logic [K_W-1:0]                       row_r;
  logic [K_W-1:0]                       col_r;
  logic [ADDR_W-1:0]                    clr_addr_r;

  logic                                 slot_free_s;
  logic                                 cmd_ready_s;
  logic                                 cmd_fire_s;
  logic                                 bank_ok_s;
  logic [K_W-1:0]                       k_s;
  logic                                 col_end_s;
  logic                                 win_last_s;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] rd_word_s;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] win_word_s;
  logic [31:0]                          win_row_s [NUM_UNITS];
  logic [31:0]                          win_col_s [NUM_UNITS];
  logic [31:0]                          win_lin_s [NUM_UNITS];

  assign slot_free_s = !rd_valid_r || bus.rd_ready;
  assign cmd_ready_s = (state_r == ST_IDLE) && slot_free_s;
  assign cmd_fire_s  = bus.cmd_valid && cmd_ready_s;
  assign bank_ok_s   = (32'(bus.cmd_bank) < 32'(NUM_BANKS));
  assign k_s         = (bus.kernel_dim == {K_W{1'b0}}) ? K_ONE : bus.kernel_dim;
  assign col_end_s   = (col_r == (k_r - K_ONE));
  assign win_last_s  = col_end_s && (row_r == (k_r - K_ONE));

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_last   = rd_last_r;
  assign bus.busy      = busy_r;

  // Per-lane READ words and zero-padded window elements (no wrap across rows).
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      rd_word_s[i] = mem_r[bus.cmd_bank][bus.cmd_addr[i]];
      win_row_s[i] = 32'(start_r[i]) / 32'(IMAGE_WIDTH) + 32'(row_r);
      win_col_s[i] = 32'(start_r[i]) % 32'(IMAGE_WIDTH) + 32'(col_r);
      win_lin_s[i] = win_row_s[i] * 32'(IMAGE_WIDTH) + win_col_s[i];
      if ((win_row_s[i] < 32'(IMAGE_HEIGHT)) && (win_col_s[i] < 32'(IMAGE_WIDTH))) begin
        win_word_s[i] = mem_r[bank_r][ADDR_W'(win_lin_s[i])];
      end else begin
        win_word_s[i] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Bank array write port: lane writes (highest lane wins) or clear sweep.
  always_ff @(posedge clk) begin
    if (!reset && cmd_fire_s && bank_ok_s && (bus.cmd_op == OP_WRITE)) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        mem_r[bus.cmd_bank][bus.cmd_addr[i]] <= bus.cmd_data[i];
      end
    end else if (!reset && (state_r == ST_CLEAR)) begin
      mem_r[bank_r][clr_addr_r] <= {DATA_WIDTH{1'b0}};
    end
  end

  // Control FSM and the registered output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= {(NUM_UNITS * DATA_WIDTH){1'b0}};
      bank_r     <= {BANK_W{1'b0}};
      start_r    <= {(NUM_UNITS * ADDR_W){1'b0}};
      k_r        <= {K_W{1'b0}};
      row_r      <= {K_W{1'b0}};
      col_r      <= {K_W{1'b0}};
      clr_addr_r <= {ADDR_W{1'b0}};
    end else begin
      // A consumed beat empties the slot unless a new beat is loaded below.
      if (slot_free_s) begin
        rd_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s && bank_ok_s) begin
            case (bus.cmd_op)
              OP_READ: begin
                rd_valid_r <= 1'b1;
                rd_data_r  <= rd_word_s;
                rd_last_r  <= 1'b1;
              end
              OP_WINDOW: begin
                bank_r  <= bus.cmd_bank;
                start_r <= bus.cmd_addr;
                k_r     <= k_s;
                row_r   <= {K_W{1'b0}};
                col_r   <= {K_W{1'b0}};
                state_r <= ST_WINDOW;
                busy_r  <= 1'b1;
              end
              OP_CLEAR: begin
                bank_r     <= bus.cmd_bank;
                clr_addr_r <= {ADDR_W{1'b0}};
                state_r    <= ST_CLEAR;
                busy_r     <= 1'b1;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_WINDOW: begin
          if (slot_free_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= win_word_s;
            rd_last_r  <= win_last_s;
            if (win_last_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else if (col_end_s) begin
              col_r <= {K_W{1'b0}};
              row_r <= row_r + K_ONE;
            end else begin
              col_r <= col_r + K_ONE;
            end
          end
        end
        ST_CLEAR: begin
          clr_addr_r <= clr_addr_r + ADDR_ONE;
          if (clr_addr_r == ADDR_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_bank_memory.sv
// Directed bench for multi_bank_memory: lane write/read, windows with padding,
// backpressure, clear and mid-window reset, against hand-computed values.
module tb_multi_bank_memory;
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WIN = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  multi_bank_memory_if #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8),
                         .NUM_UNITS(2), .NUM_BANKS(4)) bus ();

  multi_bank_memory #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8),
                      .NUM_UNITS(2), .NUM_BANKS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one command for a single edge; caller ensures the port is idle.
  task automatic issue_cmd(input logic [1:0] op, input logic [1:0] bank,
                           input logic [5:0] a0, input logic [5:0] a1,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [2:0] k);
    bus.cmd_op      = op;
    bus.cmd_bank    = bank;
    bus.cmd_addr[0] = a0;
    bus.cmd_addr[1] = a1;
    bus.cmd_data[0] = d0;
    bus.cmd_data[1] = d1;
    bus.kernel_dim  = k;
    bus.cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic fill_bank(input logic [1:0] bank, input logic [15:0] base);
    for (int a = 0; a < 64; a += 2) begin
      issue_cmd(OP_WR, bank, 6'(a), 6'(a + 1), base + 16'(a), base + 16'(a + 1), 3'd0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.busy !== 1'b0 ||
        bus.rd_data !== 32'h0 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b data=%h ready=%b, need 0 0 0 00000000 1",
               bus.rd_valid, bus.rd_last, bus.busy, bus.rd_data, bus.cmd_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    fill_bank(2'd0, 16'h0000);
    issue_cmd(OP_WR, 2'd1, 6'd3, 6'd5, 16'h0011, 16'h0022, 3'd0);
    issue_cmd(OP_RD, 2'd1, 6'd5, 6'd3, 16'h0000, 16'h0000, 3'd0);
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_last !== 1'b1 ||
        bus.rd_data[0] !== 16'h0022 || bus.rd_data[1] !== 16'h0011) begin
      tests_failed++;
      $display("FAIL read_bank1: valid=%b last=%b lane0=%h lane1=%h, need 1 1 0022 0011",
               bus.rd_valid, bus.rd_last, bus.rd_data[0], bus.rd_data[1]);
    end
    issue_cmd(OP_RD, 2'd0, 6'd5, 6'd3, 16'h0000, 16'h0000, 3'd0);
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'h0005 || bus.rd_data[1] !== 16'h0003) begin
      tests_failed++;
      $display("FAIL read_bank0_untouched: valid=%b lane0=%h lane1=%h, need 1 0005 0003",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1]);
    end
  endtask

  task automatic test_window_k2();
    logic [15:0] e0 [4];
    logic [15:0] e1 [4];
    e0 = '{16'd0, 16'd1, 16'd8, 16'd9};
    e1 = '{16'd9, 16'd10, 16'd17, 16'd18};
    issue_cmd(OP_WIN, 2'd0, 6'd0, 6'd9, 16'h0000, 16'h0000, 3'd2);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== e0[b] || bus.rd_data[1] !== e1[b] ||
          bus.rd_last !== (b == 3) || bus.busy !== (b != 3)) begin
        tests_failed++;
        $display("FAIL window_k2 beat%0d: valid=%b lane0=%0d lane1=%0d last=%b busy=%b, need 1 %0d %0d %b %b",
                 b + 1, bus.rd_valid, bus.rd_data[0], bus.rd_data[1], bus.rd_last, bus.busy,
                 e0[b], e1[b], (b == 3), (b != 3));
      end
    end
  endtask

  task automatic test_window_k3_padding();
    logic [15:0] e0 [9];
    logic [15:0] e1 [9];
    e0 = '{16'd6, 16'd7, 16'd0, 16'd14, 16'd15, 16'd0, 16'd22, 16'd23, 16'd0};
    e1 = '{16'd62, 16'd63, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    issue_cmd(OP_WIN, 2'd0, 6'd6, 6'd62, 16'h0000, 16'h0000, 3'd3);
    for (int b = 0; b < 9; b++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== e0[b] || bus.rd_data[1] !== e1[b] ||
          bus.rd_last !== (b == 8)) begin
        tests_failed++;
        $display("FAIL window_k3 beat%0d: valid=%b lane0=%0d lane1=%0d last=%b, need 1 %0d %0d %b",
                 b + 1, bus.rd_valid, bus.rd_data[0], bus.rd_data[1], bus.rd_last,
                 e0[b], e1[b], (b == 8));
      end
    end
  endtask

  task automatic test_backpressure();
    issue_cmd(OP_WIN, 2'd0, 6'd0, 6'd9, 16'h0000, 16'h0000, 3'd2);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd0 || bus.rd_data[1] !== 16'd9) begin
      tests_failed++;
      $display("FAIL bp_beat1: valid=%b lane0=%0d lane1=%0d, need 1 0 9",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1]);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd1 || bus.rd_data[1] !== 16'd10) begin
      tests_failed++;
      $display("FAIL bp_beat2: valid=%b lane0=%0d lane1=%0d, need 1 1 10",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1]);
    end
    // Stall the consumer and offer a READ that must wait for the window.
    bus.rd_ready    = 1'b0;
    bus.cmd_op      = OP_RD;
    bus.cmd_bank    = 2'd0;
    bus.cmd_addr[0] = 6'd2;
    bus.cmd_addr[1] = 6'd4;
    bus.cmd_valid   = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd1 || bus.rd_data[1] !== 16'd10 ||
          bus.rd_last !== 1'b0 || bus.cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_stall%0d: valid=%b lane0=%0d lane1=%0d last=%b ready=%b, need 1 1 10 0 0",
                 s, bus.rd_valid, bus.rd_data[0], bus.rd_data[1], bus.rd_last, bus.cmd_ready);
      end
    end
    bus.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd8 || bus.rd_data[1] !== 16'd17 ||
        bus.rd_last !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_beat3: valid=%b lane0=%0d lane1=%0d last=%b ready=%b, need 1 8 17 0 0",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1], bus.rd_last, bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd9 || bus.rd_data[1] !== 16'd18 ||
        bus.rd_last !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_beat4: valid=%b lane0=%0d lane1=%0d last=%b busy=%b, need 1 9 18 1 0",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1], bus.rd_last, bus.busy);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd2 || bus.rd_data[1] !== 16'd4 ||
        bus.rd_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_held_read: valid=%b lane0=%0d lane1=%0d last=%b, need 1 2 4 1",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1], bus.rd_last);
    end
  endtask

  task automatic test_clear();
    int n;
    fill_bank(2'd2, 16'h0200);
    fill_bank(2'd3, 16'h0300);
    issue_cmd(OP_CLR, 2'd2, 6'd0, 6'd0, 16'h0000, 16'h0000, 3'd0);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (n != 64) begin
      tests_failed++;
      $display("FAIL clear_busy_cycles: busy for %0d cycles, need 64", n);
    end
    issue_cmd(OP_RD, 2'd2, 6'd0, 6'd63, 16'h0000, 16'h0000, 3'd0);
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'h0000 || bus.rd_data[1] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL clear_bank2_a: valid=%b lane0=%h lane1=%h, need 1 0000 0000",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1]);
    end
    issue_cmd(OP_RD, 2'd2, 6'd7, 6'd32, 16'h0000, 16'h0000, 3'd0);
    tests_run++;
    if (bus.rd_data[0] !== 16'h0000 || bus.rd_data[1] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL clear_bank2_b: lane0=%h lane1=%h, need 0000 0000",
               bus.rd_data[0], bus.rd_data[1]);
    end
    issue_cmd(OP_RD, 2'd3, 6'd0, 6'd63, 16'h0000, 16'h0000, 3'd0);
    tests_run++;
    if (bus.rd_data[0] !== 16'h0300 || bus.rd_data[1] !== 16'h033F) begin
      tests_failed++;
      $display("FAIL clear_bank3_intact: lane0=%h lane1=%h, need 0300 033f",
               bus.rd_data[0], bus.rd_data[1]);
    end
    issue_cmd(OP_WR, 2'd2, 6'd7, 6'd7, 16'h000A, 16'h000B, 3'd0);
    issue_cmd(OP_RD, 2'd2, 6'd7, 6'd7, 16'h0000, 16'h0000, 3'd0);
    tests_run++;
    if (bus.rd_data[0] !== 16'h000B || bus.rd_data[1] !== 16'h000B) begin
      tests_failed++;
      $display("FAIL same_addr_high_lane: lane0=%h lane1=%h, need 000b 000b",
               bus.rd_data[0], bus.rd_data[1]);
    end
  endtask

  task automatic test_reset_mid_window();
    issue_cmd(OP_WIN, 2'd0, 6'd0, 6'd9, 16'h0000, 16'h0000, 3'd2);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_window_beat2: valid=%b lane0=%0d busy=%b, need 1 1 1",
               bus.rd_valid, bus.rd_data[0], bus.busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_abort: valid=%b busy=%b ready=%b, need 0 0 1",
               bus.rd_valid, bus.busy, bus.cmd_ready);
    end
    issue_cmd(OP_RD, 2'd0, 6'd1, 6'd2, 16'h0000, 16'h0000, 3'd0);
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data[0] !== 16'd1 || bus.rd_data[1] !== 16'd2 ||
        bus.rd_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_after_reset: valid=%b lane0=%0d lane1=%0d last=%b, need 1 1 2 1",
               bus.rd_valid, bus.rd_data[0], bus.rd_data[1], bus.rd_last);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_WR;
    bus.cmd_bank   = 2'd0;
    bus.cmd_addr   = 12'h000;
    bus.cmd_data   = 32'h0;
    bus.kernel_dim = 3'd0;
    bus.rd_ready   = 1'b1;
    test_reset();
    test_write_read();
    test_window_k2();
    test_window_k3_padding();
    test_backpressure();
    test_clear();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
